// File: rtl/tf_table_loader6_if.sv
// Bundle of the load-stream, read-port and status signals of tf_table_loader6.
//   master: the producer/consumer side (testbench or stage-6 control)
//   slave : the table loader itself
interface tf_table_loader6_if #(
  parameter int unsigned float_len        = 32,
  parameter int unsigned bram_tf_addr_len = 5
);

  localparam int unsigned DATA_W = 2 * float_len;
  localparam int unsigned ADDR_W = bram_tf_addr_len;
  localparam int unsigned CNT_W  = bram_tf_addr_len + 1;

  // load control and write stream
  logic              load_start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  // synchronous read port
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;

  // status
  logic              table_ready;
  logic [CNT_W-1:0]  word_cnt;
  logic              load_err;

  modport master (
    output load_start, in_data, in_valid, rd_en, rd_addr,
    input  in_ready, rd_data, rd_data_valid, table_ready, word_cnt, load_err
  );

  modport slave (
    input  load_start, in_data, in_valid, rd_en, rd_addr,
    output in_ready, rd_data, rd_data_valid, table_ready, word_cnt, load_err
  );

endinterface

// File: rtl/tf_table_loader6.sv
// Run-time loadable twiddle-factor table for the stage-6 butterfly.
// Accepts packed complex words {real, imag} over a valid/ready stream,
// fills a tf_num-deep table, then serves registered reads.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     load_start, in_data/in_valid/in_ready write stream,
//                   rd_en/rd_addr/rd_data/rd_data_valid read port,
//                   table_ready, word_cnt, load_err status
module tf_table_loader6 #(
  parameter int unsigned float_len        = 32,
  parameter int unsigned tf_num           = 32,
  parameter int unsigned bram_tf_addr_len = 5
) (
  input  logic                clk,
  input  logic                rst,
  tf_table_loader6_if.slave   bus
);

  localparam int unsigned DATA_W = 2 * float_len;
  localparam int unsigned ADDR_W = bram_tf_addr_len;
  localparam int unsigned CNT_W  = bram_tf_addr_len + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(tf_num - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               table_ready_q, table_ready_d;
  logic               load_err_q, load_err_d;
  logic               rd_data_valid_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               wr_en;
  logic               accept;

  // table storage; deliberately not reset, only table_ready qualifies it
  logic [DATA_W-1:0]  mem [tf_num];

  // in_ready_q is high exactly while in LOAD, so it doubles as the state gate
  assign accept = bus.in_valid & in_ready_q;

  // state and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      word_cnt_q    <= '0;
      in_ready_q    <= 1'b0;
      table_ready_q <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      word_cnt_q    <= word_cnt_d;
      in_ready_q    <= in_ready_d;
      table_ready_q <= table_ready_d;
      load_err_q    <= load_err_d;
    end
  end

  // next state, counters and write strobe
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    word_cnt_d = word_cnt_q;
    load_err_d = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d    = LOAD;
          wr_addr_d  = '0;
          word_cnt_d = '0;
        end
      end

      LOAD: begin
        if (bus.load_start) begin
          // restart wins over a same-cycle handshake: that word is dropped
          wr_addr_d  = '0;
          word_cnt_d = '0;
          load_err_d = 1'b1;
        end else if (accept) begin
          wr_en      = 1'b1;
          wr_addr_d  = wr_addr_q + ADDR_W'(1);
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (wr_addr_q == LAST_ADDR) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (bus.load_start) begin
          state_d    = LOAD;
          wr_addr_d  = '0;
          word_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // registered state decodes
    in_ready_d    = (state_d == LOAD);
    table_ready_d = (state_d == DONE);
  end

  // table write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr_q] <= bus.in_data;
    end
  end

  // registered read port; read-first against a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      if (bus.rd_en) begin
        rd_data_q <= mem[bus.rd_addr];
      end
      rd_data_valid_q <= bus.rd_en & table_ready_q;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.table_ready   = table_ready_q;
  assign bus.word_cnt      = word_cnt_q;
  assign bus.load_err      = load_err_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_data_valid_q;

endmodule

// File: tb/tb_tf_table_loader6.sv
// Self-checking bench for tf_table_loader6: a small table of directed
// vectors, hand sequences for the multi-cycle corners and a randomized run,
// all compared against a behavioural model of the table loader.
module tb_tf_table_loader6;

  localparam int unsigned TF_NUM = 32;

  logic clk;
  logic rst;

  tf_table_loader6_if #(.float_len(32), .bram_tf_addr_len(5)) bus ();

  tf_table_loader6 #(
    .float_len(32),
    .tf_num(32),
    .bram_tf_addr_len(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: a table plus "loading / ready / count" status
  bit          m_loading;
  bit          m_ready;
  bit          m_err;
  bit          m_rv;
  int          m_cnt;
  logic [63:0] m_rd;
  bit          m_rd_known;
  logic [63:0] m_mem [TF_NUM];
  bit          m_known [TF_NUM];

  typedef struct {
    logic        ls;
    logic        iv;
    logic [63:0] d;
    logic        e_ir;
    logic        e_tr;
    logic [5:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading  = 1'b0;
    m_ready    = 1'b0;
    m_err      = 1'b0;
    m_rv       = 1'b0;
    m_cnt      = 0;
    m_rd       = '0;
    m_rd_known = 1'b1;
  endtask

  // one clock edge of the reference behaviour, using pre-edge inputs
  task automatic model_step(input bit ls, input bit iv, input logic [63:0] d,
                            input bit re, input logic [4:0] ra);
    m_err = ls && m_loading;
    if (re) begin
      m_rd       = m_mem[ra];
      m_rd_known = m_known[ra];
    end
    m_rv = re && m_ready;
    if (ls) begin
      m_loading = 1'b1;
      m_ready   = 1'b0;
      m_cnt     = 0;
    end else if (m_loading && iv) begin
      m_mem[m_cnt]   = d;
      m_known[m_cnt] = 1'b1;
      m_cnt++;
      if (m_cnt == TF_NUM) begin
        m_loading = 1'b0;
        m_ready   = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("in_ready",      64'(bus.in_ready),      64'(m_loading));
    chk("table_ready",   64'(bus.table_ready),   64'(m_ready));
    chk("word_cnt",      64'(bus.word_cnt),      64'(m_cnt));
    chk("load_err",      64'(bus.load_err),      64'(m_err));
    chk("rd_data_valid", 64'(bus.rd_data_valid), 64'(m_rv));
    if (m_rd_known) chk("rd_data", bus.rd_data, m_rd);
  endtask

  // drive one cycle, step the model at the edge, check 1 time unit later
  task automatic cycle(input bit ls, input bit iv, input logic [63:0] d,
                       input bit re, input logic [4:0] ra);
    bus.load_start = ls;
    bus.in_valid   = iv;
    bus.in_data    = d;
    bus.rd_en      = re;
    bus.rd_addr    = ra;
    @(posedge clk);
    model_step(ls, iv, d, re, ra);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.rd_en      = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready",      64'(bus.in_ready),      64'd0);
    chk("rst_table_ready",   64'(bus.table_ready),   64'd0);
    chk("rst_word_cnt",      64'(bus.word_cnt),      64'd0);
    chk("rst_load_err",      64'(bus.load_err),      64'd0);
    chk("rst_rd_data_valid", 64'(bus.rd_data_valid), 64'd0);
    chk("rst_rd_data",       bus.rd_data,            64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // full load with in_valid held, words base+i
  task automatic full_load(input logic [63:0] base);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < int'(TF_NUM); i++) cycle(1'b0, 1'b1, base + 64'(i), 1'b0, '0);
  endtask

  task automatic readback(input string name, input logic [63:0] base);
    for (int i = 0; i < int'(TF_NUM); i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 5'(i));
      chk(name, bus.rd_data, base + 64'(i));
      chk("readback_valid", 64'(bus.rd_data_valid), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int ir_high;
    int ready_tick;
    int n;
    int errs;
    logic [63:0] rd_word;
    bit iv;

    for (int i = 0; i < int'(TF_NUM); i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    model_reset();

    bus.load_start = 1'b0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // idle after reset: everything stays at zero
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);

    // directed vectors: {ls, iv, data, in_ready, table_ready, word_cnt, load_err}
    vecs[0] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 6'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 64'h11, 1'b0, 1'b0, 6'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 6'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 64'h21, 1'b1, 1'b0, 6'd1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 64'h22, 1'b1, 1'b0, 6'd1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 64'h23, 1'b1, 1'b0, 6'd2, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 64'h24, 1'b1, 1'b0, 6'd0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 64'h25, 1'b1, 1'b0, 6'd0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 64'h26, 1'b1, 1'b0, 6'd1, 1'b0};
    foreach (vecs[k]) begin
      cycle(vecs[k].ls, vecs[k].iv, vecs[k].d, 1'b0, '0);
      chk("vec_in_ready",    64'(bus.in_ready),    64'(vecs[k].e_ir));
      chk("vec_table_ready", 64'(bus.table_ready), 64'(vecs[k].e_tr));
      chk("vec_word_cnt",    64'(bus.word_cnt),    64'(vecs[k].e_cnt));
      chk("vec_load_err",    64'(bus.load_err),    64'(vecs[k].e_err));
    end
    do_reset();

    // full load, in_valid held high
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    ticks = 1;
    ir_high = bus.in_ready ? 1 : 0;
    ready_tick = 0;
    for (int i = 0; i < int'(TF_NUM); i++) begin
      cycle(1'b0, 1'b1, 64'h3F800000_00000000 + 64'(i), 1'b0, '0);
      ticks++;
      if (bus.in_ready) ir_high++;
      if (bus.table_ready && ready_tick == 0) ready_tick = ticks;
    end
    chk("full_in_ready_cycles", 64'(ir_high), 64'd32);
    chk("full_ticks_to_ready",  64'(ready_tick), 64'd33);
    chk("full_word_cnt",        64'(bus.word_cnt), 64'd32);
    readback("full_rd_data", 64'h3F800000_00000000);

    // in_valid toggling on alternate cycles
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    n = 0;
    for (int c = 0; c < 200 && n < int'(TF_NUM); c++) begin
      iv = (c % 2 == 0);
      cycle(1'b0, iv, 64'hA000_0000_0000_0000 + 64'(n), 1'b0, '0);
      if (iv) n++;
    end
    chk("alt_accepts",    64'(n), 64'd32);
    chk("alt_table_ready", 64'(bus.table_ready), 64'd1);
    readback("alt_rd_data", 64'hA000_0000_0000_0000);

    // restart after 10 accepted words
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 64'hB000_0000_0000_0000 + 64'(i), 1'b0, '0);
    chk("restart_cnt_before", 64'(bus.word_cnt), 64'd10);
    cycle(1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, '0);
    errs = bus.load_err ? 1 : 0;
    chk("restart_cnt_cleared", 64'(bus.word_cnt), 64'd0);
    for (int i = 0; i < int'(TF_NUM); i++) begin
      cycle(1'b0, 1'b1, 64'hC000_0000_0000_0000 + 64'(i), 1'b0, '0);
      if (bus.load_err) errs++;
    end
    chk("restart_err_pulses", 64'(errs), 64'd1);
    readback("restart_rd_data", 64'hC000_0000_0000_0000);

    // reload from DONE while reading, including same-address collisions
    cycle(1'b1, 1'b0, '0, 1'b1, 5'd3);
    chk("reload_prev_valid", 64'(bus.rd_data_valid), 64'd1);
    chk("reload_prev_data",  bus.rd_data, 64'hC000_0000_0000_0003);
    chk("reload_tr_drop",    64'(bus.table_ready), 64'd0);
    for (int i = 0; i < int'(TF_NUM); i++) begin
      cycle(1'b0, 1'b1, 64'hD000_0000_0000_0000 + 64'(i), 1'b1, 5'(i));
      rd_word = 64'hC000_0000_0000_0000 + 64'(i);
      chk("collision_old_word", bus.rd_data, rd_word);
      chk("reload_valid_low", 64'(bus.rd_data_valid), 64'd0);
    end
    readback("reload_rd_data", 64'hD000_0000_0000_0000);

    // reset after 20 accepted words, then a fresh load
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 64'hE000_0000_0000_0000 + 64'(i), 1'b0, '0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 64'hEEEE, 1'b0, '0);
    chk("post_rst_cnt", 64'(bus.word_cnt), 64'd0);
    full_load(64'hF000_0000_0000_0000);
    chk("post_rst_table_ready", 64'(bus.table_ready), 64'd1);
    readback("post_rst_rd_data", 64'hF000_0000_0000_0000);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 59) == 0,
              $urandom_range(0, 3) != 0,
              {$urandom, $urandom},
              $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 31)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
